// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-time game block.
package reaction_pkg;

  typedef enum logic [2:0] {IDLE, WAIT_RAND, ARMED, DONE, FOUL} state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam logic [15:0] BCD_MAX   = 16'h9999;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Right-shifting Galois step for x^16+x^14+x^13+x^11+1.
  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    return {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD up-counter with synchronous clear that saturates at 9999.
module bcd_counter4
  import reaction_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] value,
  output logic        sat
);

  logic [15:0] incremented;
  logic        carry;
  bcd_digit_t  digit;

  // Ripple the +1 through the digits, wrapping each 9 to 0.
  always_comb begin
    incremented = value;
    carry       = 1'b1;
    digit       = '0;
    for (int i = 0; i < 4; i++) begin
      digit = value[4*i +: 4];
      if (carry) begin
        if (digit == 4'd9) begin
          incremented[4*i +: 4] = 4'd0;
        end else begin
          incremented[4*i +: 4] = digit + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  assign sat = (value == BCD_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc && !sat) begin
      value <= incremented;
    end
  end

endmodule

// File: rtl/reaction_timer.sv
// Reaction-time game FSM: random pre-LED wait, then millisecond count until
// the react button, reported as BCD with foul and timeout status.
module reaction_timer
  import reaction_pkg::*;
#(
  parameter int          MIN_DELAY_MS = 1000,
  parameter int          RAND_BITS    = 10,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        msec_pulse,
  input  logic        start_btn,
  input  logic        react_btn,
  output logic        led,
  output logic        busy,
  output logic        done,
  output logic        foul,
  output logic        timeout,
  output logic [15:0] reaction_bcd
);

  localparam int DW = $clog2(MIN_DELAY_MS + 2**RAND_BITS);

  state_t          state, state_n;
  logic [15:0]     lfsr;
  logic [DW-1:0]   delay_cnt;
  logic            start_q, react_q;
  logic            start_rise, react_rise;
  logic            cnt_clr, cnt_inc, cnt_sat, hit_sat;

  assign start_rise = start_btn & ~start_q;
  assign react_rise = react_btn & ~react_q;

  // A react press beats a coincident final delay pulse or count pulse.
  always_comb begin
    state_n = state;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    hit_sat = 1'b0;
    case (state)
      IDLE, DONE, FOUL: begin
        if (start_rise) begin
          state_n = WAIT_RAND;
          cnt_clr = 1'b1;
        end
      end
      WAIT_RAND: begin
        if (react_rise) begin
          state_n = FOUL;
        end else if (msec_pulse && delay_cnt == DW'(1)) begin
          state_n = ARMED;
        end
      end
      ARMED: begin
        if (react_rise) begin
          state_n = DONE;
        end else if (msec_pulse) begin
          if (cnt_sat) begin
            state_n = DONE;
            hit_sat = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      lfsr      <= LFSR_SEED;
      delay_cnt <= '0;
      start_q   <= 1'b0;
      react_q   <= 1'b0;
      led       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      foul      <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      start_q <= start_btn;
      react_q <= react_btn;
      lfsr    <= lfsr_step(lfsr);
      state   <= state_n;
      led     <= (state_n == ARMED);
      busy    <= (state_n == WAIT_RAND) || (state_n == ARMED);
      done    <= (state_n == DONE);
      foul    <= (state_n == FOUL);
      if (cnt_clr) begin
        timeout <= 1'b0;
      end else if (hit_sat) begin
        timeout <= 1'b1;
      end
      if (cnt_clr) begin
        delay_cnt <= DW'(MIN_DELAY_MS) + DW'(lfsr[RAND_BITS-1:0]);
      end else if (state == WAIT_RAND && msec_pulse && !react_rise) begin
        delay_cnt <= delay_cnt - DW'(1);
      end
    end
  end

  bcd_counter4 u_count (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .value (reaction_bcd),
    .sat   (cnt_sat)
  );

endmodule

// File: doc/reaction_timer.md
Name: reaction_timer

Overview:
- Reaction-time measurement FSM for the game. Sits directly downstream of the millisecond tick generator and consumes its one-cycle `msec_pulse`.
- On a start press it waits a pseudo-random delay, lights the target LED, then counts milliseconds until the react button is pressed.
- Presents the result as 4-digit BCD (0–9999 ms) to the display driver, along with foul (early press) and timeout status.

Parameters:
- MIN_DELAY_MS, 1000, fixed part of the pre-LED wait in ms; legal range 1..50000.
- RAND_BITS, 10, width of the random part of the wait; random part is 0..2^RAND_BITS-1 ms; legal range 1..15.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be non-zero.

Ports:
- clk  in  1  system clock, same domain as the tick generator.
- rst_n  in  1  asynchronous active-low reset.
- msec_pulse  in  1  one-cycle pulse, one per millisecond.
- start_btn  in  1  start button level; already synchronized and debounced.
- react_btn  in  1  react button level; already synchronized and debounced.
- led  out  1  target LED; high only in ARMED.
- busy  out  1  high in WAIT_RAND and ARMED.
- done  out  1  level; high in DONE.
- foul  out  1  level; high in FOUL.
- timeout  out  1  level; high in DONE when the count saturated.
- reaction_bcd  out  16  four BCD digits, [15:12] thousands … [3:0] units.

Behaviour:
- Reset (async assert, sync release): state=IDLE; all outputs 0; reaction_bcd=16'h0000; lfsr=LFSR_SEED; edge-detect registers=0.
- All outputs are registered and decoded from the registered state, so they change on the clock edge that updates the state.
- Edge detect: start_rise = start_btn & ~start_q; react_rise = react_btn & ~react_q. Levels are ignored; only rising edges act.
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1.
  - Advances every clk cycle in every state, never reloaded except by reset.
- IDLE/DONE/FOUL on start_rise → WAIT_RAND:
  - load delay_cnt = MIN_DELAY_MS + lfsr[RAND_BITS-1:0], using the pre-advance lfsr value of that cycle;
  - clear reaction_bcd, timeout and foul.
- WAIT_RAND:
  - msec_pulse decrements delay_cnt.
  - If msec_pulse arrives with delay_cnt==1 → ARMED, so the LED turns on exactly D pulses after entry.
  - react_rise → FOUL. This wins over a simultaneous final pulse.
  - start_rise is ignored.
- ARMED:
  - led=1.
  - reaction_bcd increments by 1 (BCD carry 9→0) on each msec_pulse.
  - react_rise → DONE and the count freezes; if react_rise and msec_pulse occur in the same cycle, that pulse is NOT counted.
  - If the count is 9999 when a msec_pulse arrives: no increment (saturate), → DONE with timeout=1.
  - start_rise is ignored.
- DONE: reaction_bcd holds; done=1. Only start_rise leaves.
- FOUL: foul=1; reaction_bcd=0. Only start_rise leaves.
- delay_cnt width: $clog2(MIN_DELAY_MS+2^RAND_BITS).
- Live count is visible on reaction_bcd during ARMED.
- Reset mid-operation returns immediately to the reset values.

Decomposition:
- Package reaction_pkg:
  - state enum {IDLE, WAIT_RAND, ARMED, DONE, FOUL};
  - bcd_digit_t (4 bits);
  - BCD_MAX = 16'h9999;
  - LFSR taps mask 16'hB400.
- One sub-module, bcd_counter4: clr, inc, saturates at 9999, outputs a sat flag. Used for reaction_bcd.
- The FSM, LFSR and delay counter stay in reaction_timer.

Test Plan:
- Reset while ARMED with reaction_bcd=0x0042 → all outputs 0 asynchronously; state IDLE; LFSR back to seed.
- MIN_DELAY_MS=3, RAND_BITS=1; bench mirrors the LFSR; start_rise → led rises exactly on the cycle of the D-th msec_pulse (D=3 or 4 per model); busy=1 from the next edge.
- ARMED; issue 250 msec_pulses, then react_rise → done=1, reaction_bcd=16'h0250, led=0; counts stay frozen under further pulses.
- react_rise on the same cycle as the 7th pulse after ARMED → reaction_bcd=16'h0006.
- react_rise during WAIT_RAND → foul=1, reaction_bcd=0, led never asserts; a new start_rise clears foul and re-enters WAIT_RAND.
- ARMED with no press → after 9999 pulses reaction_bcd=16'h9999; the next pulse gives done=1, timeout=1, value stays 9999; holding react_btn high across the start gives no react_rise.
